nco_phase_sweeper: RTL

- Phase-generation stage directly upstream of the sine LUT.
- Accumulates a frequency control word (FCW) into a PHASE_WIDTH-bit phase. The phase MSBs address the LUT.
- Supports constant tones and programmable linear sweeps (chirps): start FCW, signed step, step count and per-step dwell, loaded through a valid/ready config handshake.

---
 rtl/nco_phase_sweeper.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nco_phase_sweeper.sv
// Phase accumulator feeding the sine LUT, with programmable linear FCW sweeps.
// Config is accepted through a valid/ready handshake only while idle.
module nco_phase_sweeper #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_start_fcw,
    input  logic [PHASE_WIDTH-1:0] cfg_step_fcw,
    input  logic [COUNT_WIDTH-1:0] cfg_num_steps,
    input  logic [COUNT_WIDTH-1:0] cfg_dwell,
    input  logic                   sweep_abort,
    input  logic                   phase_sync,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   phase_valid,
    output logic [PHASE_WIDTH-1:0] fcw,
    output logic                   sweep_active,
    output logic                   sweep_done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] fcw_q, fcw_d;
    logic [PHASE_WIDTH-1:0] step_q, step_d;
    logic [COUNT_WIDTH-1:0] steps_left_q, steps_left_d;
    logic [COUNT_WIDTH-1:0] dwell_q, dwell_d;
    logic [COUNT_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic                   phase_valid_q, phase_valid_d;
    logic                   sweep_done_q, sweep_done_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            fcw_q         <= '0;
            step_q        <= '0;
            steps_left_q  <= '0;
            dwell_q       <= '0;
            dwell_cnt_q   <= '0;
            phase_valid_q <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            fcw_q         <= fcw_d;
            step_q        <= step_d;
            steps_left_q  <= steps_left_d;
            dwell_q       <= dwell_d;
            dwell_cnt_q   <= dwell_cnt_d;
            phase_valid_q <= phase_valid_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    // Next-state: phase always accumulates on the pre-update fcw
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        fcw_d         = fcw_q;
        step_d        = step_q;
        steps_left_d  = steps_left_q;
        dwell_d       = dwell_q;
        dwell_cnt_d   = dwell_cnt_q;
        phase_valid_d = sample_en;
        sweep_done_d  = 1'b0;

        if (sample_en) begin
            phase_d = phase_q + fcw_q;
        end
        if (phase_sync) begin
            phase_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    fcw_d        = cfg_start_fcw;
                    step_d       = cfg_step_fcw;
                    steps_left_d = cfg_num_steps;
                    dwell_cnt_d  = '0;
                    dwell_d      = (cfg_dwell == '0) ? COUNT_WIDTH'(1) : cfg_dwell;
                    if (cfg_num_steps != '0) begin
                        state_d = ST_SWEEP;
                    end
                end
            end
            ST_SWEEP: begin
                if (sweep_abort) begin
                    state_d = ST_IDLE;
                end else if (sample_en) begin
                    // dwell_cnt_q < dwell_q always holds here, so the +1 cannot wrap
                    if (dwell_cnt_q + COUNT_WIDTH'(1) == dwell_q) begin
                        fcw_d        = fcw_q + step_q;
                        dwell_cnt_d  = '0;
                        steps_left_d = steps_left_q - COUNT_WIDTH'(1);
                        if (steps_left_q == COUNT_WIDTH'(1)) begin
                            state_d      = ST_IDLE;
                            sweep_done_d = 1'b1;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + COUNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cfg_ready    = (state_q == ST_IDLE);
    assign sweep_active = (state_q == ST_SWEEP);
    assign phase        = phase_q;
    assign fcw          = fcw_q;
    assign phase_valid  = phase_valid_q;
    assign sweep_done   = sweep_done_q;

endmodule
